lfsr_sequencer: RTL and testbench

Controller that owns one `ShiftRegister` instance and runs it as a Fibonacci LFSR.
- Latches a seed and loads it through the register's load path.
- Computes the feedback bit from a tap mask.
- Clocks the register `STEPS` times per output word.
- Presents each completed state as a word on a valid/ready stream.

It sits between the configuration interface and any consumer of pseudo-random words; the shift register itself stays a dumb datapath.

---
 rtl/lfsr_sequencer.sv | 133 +++++++++++++
 tb/tb_lfsr_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sequencer.sv
// Fibonacci LFSR controller driving an external shift register datapath.
// Loads a seed, shifts STEPS times per word, presents words on valid/ready.
module lfsr_sequencer #(
    parameter int unsigned      NBITS = 8,
    parameter logic [NBITS-1:0] TAPS  = 8'hB8,
    parameter int unsigned      STEPS = NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] cfg_seed,
    input  logic             cfg_load,
    input  logic             run,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [NBITS-1:0] word_data,
    output logic             busy,
    output logic             zero_seed,
    output logic [15:0]      word_count,
    output logic             sr_rst,
    output logic             sr_en,
    output logic             sr_shift_in,
    output logic [NBITS-1:0] sr_seed,
    input  logic [NBITS-1:0] sr_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_PRESENT
    } state_t;

    localparam logic [7:0]       LP_LAST = 8'(STEPS - 1);
    localparam logic [NBITS-1:0] LP_ONE  = NBITS'(1);

    state_t           r_state;
    state_t           w_nxt;
    logic [NBITS-1:0] r_seed;
    logic [7:0]       r_step;
    logic [15:0]      r_count;
    logic             r_zero;
    logic             r_valid;
    logic             r_busy;
    logic             r_en;
    logic             r_load;
    logic             w_q_zero;
    logic             w_seed_zero;

    assign w_q_zero    = (sr_q == '0);
    assign w_seed_zero = (cfg_seed == '0);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_nxt = S_IDLE;
            S_LOAD: w_nxt = S_FILL;
            S_FILL: begin
                if (w_q_zero) begin
                    w_nxt = S_LOAD;
                end else if (r_step == LP_LAST) begin
                    w_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (word_ready) begin
                    w_nxt = run ? S_FILL : S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        // A load aborts whatever is in flight, even a word being accepted.
        if (cfg_load) begin
            w_nxt = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_seed  <= LP_ONE;
            r_step  <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_valid <= (w_nxt == S_PRESENT);
            r_busy  <= (w_nxt != S_IDLE);
            r_en    <= (w_nxt == S_FILL);
            r_load  <= (w_nxt == S_LOAD);
            unique case (r_state)
                S_IDLE: r_step <= '0;
                S_LOAD: begin
                    r_step  <= '0;
                    r_count <= '0;
                end
                S_FILL: begin
                    // All-zero state never leaves itself; reseed with 1.
                    if (w_q_zero) begin
                        r_seed <= LP_ONE;
                    end else begin
                        r_step <= r_step + 8'd1;
                    end
                end
                S_PRESENT: begin
                    if (word_ready) begin
                        r_count <= r_count + 16'd1;
                        r_step  <= '0;
                    end
                end
                default: r_step <= '0;
            endcase
            if (cfg_load) begin
                r_seed <= w_seed_zero ? LP_ONE : cfg_seed;
                r_zero <= w_seed_zero;
            end
        end
    end

    assign sr_shift_in = ^(sr_q & TAPS);
    assign sr_rst      = ~rst_n | r_load;
    assign sr_seed     = rst_n ? r_seed : LP_ONE;
    assign sr_en       = r_en;
    assign word_valid  = r_valid;
    assign word_data   = sr_q;
    assign busy        = r_busy;
    assign zero_seed   = r_zero;
    assign word_count  = r_count;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer with a shift register model attached.
// Expected words come from an arithmetic LFSR model, keyed by load epoch.
module tb_lfsr_sequencer;

    localparam int         NB = 4;
    localparam logic [3:0] TP = 4'b0011;
    localparam int         ST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_seed;
    logic        cfg_load;
    logic        run;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  word_data;
    logic        busy;
    logic        zero_seed;
    logic [15:0] word_count;
    logic        sr_rst;
    logic        sr_en;
    logic        sr_shift_in;
    logic [3:0]  sr_seed;
    logic [3:0]  sr_q;

    typedef struct {
        int         ep;
        logic [3:0] d;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   drv_ep = 0;

    always #5 clk = ~clk;

    lfsr_sequencer #(.NBITS(NB), .TAPS(TP), .STEPS(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_seed   (cfg_seed),
        .cfg_load   (cfg_load),
        .run        (run),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .busy       (busy),
        .zero_seed  (zero_seed),
        .word_count (word_count),
        .sr_rst     (sr_rst),
        .sr_en      (sr_en),
        .sr_shift_in(sr_shift_in),
        .sr_seed    (sr_seed),
        .sr_q       (sr_q)
    );

    // The shift register the controller drives.
    always @(posedge clk) begin
        if (sr_rst) sr_q <= sr_seed;
        else if (sr_en) sr_q <= {sr_shift_in, sr_q[3:1]};
    end

    function automatic logic [3:0] lfsr_after(input logic [3:0] s, input int n);
        int v;
        int fb;
        v = int'(s);
        for (int i = 0; i < n; i++) begin
            fb = 0;
            for (int j = 0; j < NB; j++) begin
                if (TP[j]) fb = fb ^ ((v >> j) & 1);
            end
            v = v / 2 + fb * (1 << (NB - 1));
        end
        return 4'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [3:0] s);
        exp_t       e;
        logic [3:0] s0;
        s0 = (s == 4'd0) ? 4'd1 : s;
        drv_ep++;
        for (int i = 1; i <= 64; i++) begin
            e.ep = drv_ep;
            e.d  = lfsr_after(s0, i * ST);
            sbq.push_back(e);
        end
    endtask

    task automatic do_load(input logic [3:0] s);
        push_seq(s);
        cfg_seed = s;
        cfg_load = 1'b1;
        tick;
        cfg_load = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!word_valid && k < 40) begin
            tick;
            k++;
        end
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (busy && k < lim) begin
            tick;
            k++;
        end
        chk("idle_reached", busy, 0);
    endtask

    // Monitor: compares every accepted word against the scoreboard queue.
    initial begin
        int         mon_ep;
        int         exp_cnt;
        bit         exp_zero;
        bit         clr_pend;
        bit         hold;
        logic [3:0] hold_d;
        exp_t       e;
        mon_ep   = 0;
        exp_cnt  = 0;
        exp_zero = 0;
        clr_pend = 0;
        hold     = 0;
        hold_d   = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_cnt  = 0;
                exp_zero = 0;
                clr_pend = 0;
                hold     = 0;
            end else begin
                chk("word_count", word_count, exp_cnt);
                chk("zero_seed", zero_seed, exp_zero);
                if (word_valid) begin
                    chk("sr_en_while_valid", sr_en, 0);
                    chk("data_is_sr_q", word_data, sr_q);
                end
                if (hold) begin
                    chk("hold_valid", word_valid, 1);
                    chk("hold_data", word_data, hold_d);
                end
                if (clr_pend) begin
                    exp_cnt  = 0;
                    clr_pend = 0;
                end
                if (word_valid && word_ready) begin
                    while (sbq.size() > 0 && sbq[0].ep < mon_ep) void'(sbq.pop_front());
                    if (sbq.size() == 0) begin
                        chk("scoreboard_nonempty", 0, 1);
                    end else begin
                        e = sbq.pop_front();
                        chk("word", word_data, e.d);
                        chk("word_epoch", e.ep, mon_ep);
                    end
                    exp_cnt = (exp_cnt + 1) % 65536;
                end
                hold   = word_valid && !word_ready && !cfg_load;
                hold_d = word_data;
                if (cfg_load) begin
                    mon_ep++;
                    clr_pend = 1;
                    exp_zero = (cfg_seed == 4'd0);
                end
            end
        end
    end

    initial begin
        int         k;
        int         nw;
        int         cyc;
        int         dups;
        int         since;
        logic [3:0] w[16];
        int         tw[16];
        logic [3:0] s;

        rst_n      = 1'b0;
        cfg_seed   = 4'd0;
        cfg_load   = 1'b0;
        run        = 1'b0;
        word_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        chk("reset_sr_q", sr_q, 1);
        chk("reset_valid", word_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", word_count, 0);

        // First word, then backpressure.
        do_load(4'h1);
        chk("load_busy", busy, 1);
        wait_valid(k);
        chk("first_valid_latency", k, ST + 2);
        chk("first_word", word_data, 9);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", word_valid, 1);
            chk("bp_data", word_data, 9);
            chk("bp_sr_en", sr_en, 0);
            tick;
        end
        word_ready = 1'b1;
        tick;
        word_ready = 1'b0;
        chk("bp_count", word_count, 1);
        chk("bp_idle", busy, 0);

        // Continuous stream.
        run        = 1'b1;
        word_ready = 1'b1;
        do_load(4'h1);
        nw  = 0;
        cyc = 0;
        while (nw < 16 && cyc < 200) begin
            if (word_valid) begin
                w[nw]  = word_data;
                tw[nw] = cyc;
                if (nw == 2) chk("count_after_two", word_count, 2);
                nw++;
            end
            tick;
            cyc++;
        end
        chk("cont_nwords", nw, 16);
        chk("cont_w0", w[0], 9);
        chk("cont_w1", w[1], 5);
        chk("cont_repeat", w[15], 9);
        for (int i = 1; i < 16; i++) chk("cont_spacing", tw[i] - tw[i-1], ST + 1);
        dups = 0;
        for (int i = 0; i < 15; i++) begin
            if (w[i] == 4'd0) dups++;
            for (int j = 0; j < i; j++) if (w[i] == w[j]) dups++;
        end
        chk("cont_distinct", dups, 0);
        run = 1'b0;
        wait_idle(40);

        // Zero seed behaves as seed 1.
        do_load(4'h0);
        chk("zero_flag", zero_seed, 1);
        wait_valid(k);
        chk("zero_first_word", word_data, 9);
        tick;
        chk("zero_idle", busy, 0);

        // Restart two cycles into FILL.
        run = 1'b1;
        do_load(4'h1);
        wait_valid(k);
        tick;
        chk("rs_count_pre", word_count, 1);
        tick;
        do_load(4'h8);
        chk("rs_load_busy", busy, 1);
        chk("rs_load_valid", word_valid, 0);
        tick;
        chk("rs_count_clr", word_count, 0);
        wait_valid(k);
        chk("rs_first_word", word_data, 4'hC);
        run = 1'b0;
        wait_idle(40);

        // Randomized traffic.
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            word_ready = ($urandom_range(3) != 0);
            if ($urandom_range(49) == 0) run = ~run;
            since++;
            if ($urandom_range(29) == 0 || since > 250) begin
                since = 0;
                s     = 4'($urandom_range(15));
                push_seq(s);
                cfg_seed = s;
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            tick;
        end
        cfg_load   = 1'b0;
        run        = 1'b0;
        word_ready = 1'b1;
        wait_idle(400);
        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
